uart_resend_scheduler: RTL and testbench
========================================

// Module: uart_resend_scheduler
// PURPOSE
//  Sequences one UART frame reception with bounded retransmission. Runs a
//  per-attempt timeout counter and takes frame_valid/parity_error from the
//  even-parity receiver. It issues resend requests on a bad or missing frame
//  and declares a hard error once the retry budget is spent. It sits between
//  the UART receive datapath and the link-level host handshake (start/ack).
// PARAMETERS
//  TIMEOUT    8  WAIT cycles without frame_valid before a timeout (>=1)
//  MAX_RETRY  3  resends allowed per frame before FAIL (>=0, < 2**CNT_W)
//  CNT_W      5  width of resend_count
// PORTS
//  clk            in   1      single clock, all state on posedge
//  reset          in   1      synchronous, active-high
//  start          in   1      begin reception of a new frame (IDLE/FAIL only)
//  frame_valid    in   1      1-cycle pulse: receiver finished a frame
//  parity_error   in   1      qualified by frame_valid: frame failed parity
//  ack            in   1      host accepted delivered frame
//  busy           out  1      state != IDLE and state != FAIL
//  frame_ok       out  1      level: good frame held for host (DELIVER)
//  request_resend out  1      1-cycle pulse: ask transmitter to resend
//  error          out  1      sticky: retries exhausted (FAIL)
//  resend_count   out  CNT_W  resends issued for the current frame
// BEHAVIOUR
//  - Reset: state=IDLE, timer=0, resend_count=0, all outputs 0 on next edge.
//    Applies from any state, including mid-WAIT/RESEND; wins over all inputs.
//  - All outputs are registered/Moore, decoded from state and resend_count.
//  - IDLE: start -> WAIT, timer<=TIMEOUT, resend_count<=0.
//    frame_valid and ack ignored.
//  - WAIT: timer decrements once per WAIT cycle. Evaluate in priority order:
//    1) frame_valid & !parity_error -> DELIVER.
//    2) frame_valid & parity_error -> BAD.
//    3) no frame_valid and timer==1 (TIMEOUT-th WAIT cycle) -> BAD.
//    BAD: resend_count==MAX_RETRY -> FAIL, else -> RESEND.
//    A good frame on the timeout cycle is accepted (rule 1 wins).
//  - RESEND: exactly 1 cycle; request_resend=1.
//    Next edge: resend_count+1, timer<=TIMEOUT, -> WAIT.
//  - DELIVER: frame_ok=1 until ack. ack -> IDLE. resend_count held;
//    it clears on the next start. start/frame_valid ignored here.
//  - FAIL: error=1, resend_count held at MAX_RETRY. start -> WAIT
//    (error cleared, resend_count<=0, timer<=TIMEOUT). Else stay.
//  - Inputs in states not listed above are ignored. start in WAIT/RESEND
//    does not restart the attempt.
//  - resend_count never exceeds MAX_RETRY; no wrap. Timer width is
//    clog2(TIMEOUT+1). Timer frozen outside WAIT.
//  - Latency: frame_valid to frame_ok, or to request_resend, is 1 edge.
//    Timeout: first WAIT cycle after the start edge is cycle 1;
//    request_resend is high in cycle TIMEOUT+1.
// TESTING (TIMEOUT=8, MAX_RETRY=3)
//  1 reset; start; frame_valid=1,parity_error=0 3 cyc later -> frame_ok=1
//    next cyc, resend_count=0, busy=1; ack -> next cyc frame_ok=0, busy=0.
//  2 start; frame_valid+parity_error; later good frame -> exactly one
//    request_resend pulse, resend_count=1, frame_ok=1, error=0.
//  3 start, no frame_valid -> request_resend high in cycle 9 after start
//    edge, 1 cycle wide; resend_count=1; timer restarts (next pulse cyc 18).
//  4 start; 4 parity-error frames -> 3 request_resend pulses, then error=1,
//    busy=0, resend_count=3; start -> error=0, resend_count=0, busy=1.
//  5 start; good frame_valid exactly on WAIT cycle 8 -> DELIVER, frame_ok=1,
//    no request_resend; start during DELIVER ignored.
//  6 resend_count=2 in WAIT; assert reset 1 cyc -> next cyc all outputs 0,
//    IDLE; frame_valid without start -> no response.

Source files
------------

// File: rtl/uart_resend_scheduler.sv
// Frame reception sequencer for a UART link: per-attempt timeout, bounded
// resend requests, and a sticky hard error once the retry budget is spent.
module uart_resend_scheduler #(
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             frame_valid,
  input  logic             parity_error,
  input  logic             ack,
  output logic             busy,
  output logic             frame_ok,
  output logic             request_resend,
  output logic             error,
  output logic [CNT_W-1:0] resend_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RESEND,
    S_DELIVER,
    S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bad_attempt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nxt   = state;
    timer_nxt   = timer;
    cnt_nxt     = cnt;
    bad_attempt = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WAIT;
          timer_nxt = TMR_LOAD;
          cnt_nxt   = '0;
        end
      end

      S_WAIT: begin
        timer_nxt = timer - 1'b1;
        // A good frame wins even on the cycle the timer expires.
        if (frame_valid && !parity_error) begin
          state_nxt = S_DELIVER;
        end else if (frame_valid || (timer == TMR_LAST)) begin
          bad_attempt = 1'b1;
          state_nxt   = (cnt == CNT_MAX) ? S_FAIL : S_RESEND;
        end
      end

      S_RESEND: begin
        state_nxt = S_WAIT;
        timer_nxt = TMR_LOAD;
        cnt_nxt   = cnt + 1'b1;
      end

      S_DELIVER: begin
        if (ack) state_nxt = S_IDLE;
      end

      S_FAIL: begin
        if (start) begin
          state_nxt = S_WAIT;
          timer_nxt = TMR_LOAD;
          cnt_nxt   = '0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next-state decode, so each one equals a
  // decode of the current state without any combinational path to the pins.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      frame_ok       <= 1'b0;
      request_resend <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      cnt            <= cnt_nxt;
      busy           <= (state_nxt != S_IDLE) && (state_nxt != S_FAIL);
      frame_ok       <= (state_nxt == S_DELIVER);
      request_resend <= (state_nxt == S_RESEND);
      error          <= (state_nxt == S_FAIL);
    end
  end

  assign resend_count = cnt;

endmodule

// File: tb/tb_uart_resend_scheduler.sv
// Self-checking bench for uart_resend_scheduler: directed scenarios plus
// randomized frames checked against an attempt-level outcome model.
module tb_uart_resend_scheduler;

  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;
  localparam int CNT_W     = 5;
  localparam int OBS_W     = 4 + CNT_W;

  localparam int K_NONE = 0;
  localparam int K_GOOD = 1;
  localparam int K_BAD  = 2;

  localparam int R_GOOD   = 0;
  localparam int R_RESEND = 1;
  localparam int R_FAIL   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             frame_valid = 1'b0;
  logic             parity_error = 1'b0;
  logic             ack = 1'b0;
  logic             busy;
  logic             frame_ok;
  logic             request_resend;
  logic             error;
  logic [CNT_W-1:0] resend_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-attempt plan for one frame: what arrives and on which WAIT cycle.
  int plan_kind [MAX_RETRY+1];
  int plan_dly  [MAX_RETRY+1];

  uart_resend_scheduler #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .frame_valid   (frame_valid),
    .parity_error  (parity_error),
    .ack           (ack),
    .busy          (busy),
    .frame_ok      (frame_ok),
    .request_resend(request_resend),
    .error         (error),
    .resend_count  (resend_count)
  );

  always #5 clk = ~clk;

  wire [OBS_W-1:0] obs = {busy, frame_ok, request_resend, error, resend_count};

  function automatic logic [OBS_W-1:0] expv(input logic b, input logic o,
                                            input logic r, input logic e,
                                            input int c);
    return {b, o, r, e, CNT_W'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    start        = 1'b0;
    frame_valid  = 1'b0;
    parity_error = 1'b0;
    ack          = 1'b0;
  endtask

  task automatic set_plan(input int k0, input int d0, input int k1, input int d1,
                          input int k2, input int d2, input int k3, input int d3);
    plan_kind[0] = k0; plan_dly[0] = d0;
    plan_kind[1] = k1; plan_dly[1] = d1;
    plan_kind[2] = k2; plan_dly[2] = d2;
    plan_kind[3] = k3; plan_dly[3] = d3;
  endtask

  // One attempt with `resends` already issued; entered at WAIT cycle 1.
  // The attempt ends on the frame cycle if a frame arrives within TIMEOUT,
  // otherwise on cycle TIMEOUT; the next cycle shows its outcome.
  task automatic run_attempt(input int resends, input int kind, input int dly,
                             output int outcome);
    logic [OBS_W-1:0] exp_v;
    bool_frame: begin end
    begin
      int last;
      logic arrives;
      arrives = (kind != K_NONE) && (dly <= TIMEOUT);
      last    = arrives ? dly : TIMEOUT;
      for (int k = 1; k <= last; k++) begin
        exp_v = expv(1'b1, 1'b0, 1'b0, 1'b0, resends);
        n_compared++;
        if (obs !== exp_v) begin
          n_mismatched++;
          $display("FAIL wait_cycle%0d_r%0d: got %b required %b", k, resends, obs, exp_v);
        end
        start        = ($urandom_range(3) == 0);
        ack          = $urandom_range(1);
        frame_valid  = arrives && (k == dly);
        parity_error = (arrives && (k == dly)) ? (kind == K_BAD) : 1'($urandom_range(1));
        tick();
        quiet_inputs();
      end
      if (arrives && kind == K_GOOD) begin
        outcome = R_GOOD;
        exp_v   = expv(1'b1, 1'b1, 1'b0, 1'b0, resends);
      end else if (resends == MAX_RETRY) begin
        outcome = R_FAIL;
        exp_v   = expv(1'b0, 1'b0, 1'b0, 1'b1, MAX_RETRY);
      end else begin
        outcome = R_RESEND;
        exp_v   = expv(1'b1, 1'b0, 1'b1, 1'b0, resends);
      end
      n_compared++;
      if (obs !== exp_v) begin
        n_mismatched++;
        $display("FAIL outcome_r%0d: got %b required %b", resends, obs, exp_v);
      end
    end
  endtask

  // Starts a frame from IDLE or FAIL and plays plan_kind/plan_dly to the end.
  task automatic run_frame(input int hold, output int final_outcome);
    logic [OBS_W-1:0] exp_v;
    int outcome;
    quiet_inputs();
    start = 1'b1;
    tick();
    quiet_inputs();
    final_outcome = R_RESEND;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      run_attempt(i, plan_kind[i], plan_dly[i], outcome);
      if (outcome == R_GOOD) begin
        for (int h = 0; h < hold; h++) begin
          start        = $urandom_range(1);
          frame_valid  = $urandom_range(1);
          parity_error = $urandom_range(1);
          tick();
          quiet_inputs();
          exp_v = expv(1'b1, 1'b1, 1'b0, 1'b0, i);
          n_compared++;
          if (obs !== exp_v) begin
            n_mismatched++;
            $display("FAIL deliver_hold%0d: got %b required %b", h, obs, exp_v);
          end
        end
        ack = 1'b1;
        tick();
        quiet_inputs();
        exp_v = expv(1'b0, 1'b0, 1'b0, 1'b0, i);
        n_compared++;
        if (obs !== exp_v) begin
          n_mismatched++;
          $display("FAIL after_ack: got %b required %b", obs, exp_v);
        end
        final_outcome = R_GOOD;
        break;
      end else if (outcome == R_FAIL) begin
        frame_valid = $urandom_range(1);
        ack         = $urandom_range(1);
        tick();
        quiet_inputs();
        exp_v = expv(1'b0, 1'b0, 1'b0, 1'b1, MAX_RETRY);
        n_compared++;
        if (obs !== exp_v) begin
          n_mismatched++;
          $display("FAIL fail_sticky: got %b required %b", obs, exp_v);
        end
        final_outcome = R_FAIL;
        break;
      end else begin
        start = $urandom_range(1);
        tick();
        quiet_inputs();
      end
    end
  endtask

  task automatic test_reset();
    logic [OBS_W-1:0] exp_v;
    quiet_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_v = '0;
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL reset_state: got %b required %b", obs, exp_v);
    end
    frame_valid = 1'b1;
    ack         = 1'b1;
    tick();
    quiet_inputs();
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL idle_ignores_inputs: got %b required %b", obs, exp_v);
    end
  endtask

  task automatic test_good_frame();
    int r;
    set_plan(K_GOOD, 3, K_NONE, 0, K_NONE, 0, K_NONE, 0);
    run_frame(2, r);
  endtask

  task automatic test_parity_retry();
    int r;
    set_plan(K_BAD, 2, K_GOOD, 4, K_NONE, 0, K_NONE, 0);
    run_frame(1, r);
  endtask

  task automatic test_timeout();
    int r;
    set_plan(K_NONE, 0, K_NONE, 0, K_GOOD, 1, K_NONE, 0);
    run_frame(0, r);
  endtask

  task automatic test_fail_restart();
    int r;
    set_plan(K_BAD, 1, K_BAD, 5, K_BAD, 8, K_BAD, 2);
    run_frame(0, r);
    set_plan(K_GOOD, 2, K_NONE, 0, K_NONE, 0, K_NONE, 0);
    run_frame(1, r);
  endtask

  task automatic test_good_on_timeout();
    int r;
    set_plan(K_GOOD, TIMEOUT, K_NONE, 0, K_NONE, 0, K_NONE, 0);
    run_frame(3, r);
  endtask

  task automatic test_reset_midwait();
    logic [OBS_W-1:0] exp_v;
    int outcome;
    quiet_inputs();
    start = 1'b1;
    tick();
    quiet_inputs();
    for (int i = 0; i < 2; i++) begin
      run_attempt(i, K_BAD, 1, outcome);
      tick();
    end
    exp_v = expv(1'b1, 1'b0, 1'b0, 1'b0, 2);
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL pre_reset_wait: got %b required %b", obs, exp_v);
    end
    reset       = 1'b1;
    start       = 1'b1;
    frame_valid = 1'b1;
    tick();
    reset = 1'b0;
    quiet_inputs();
    exp_v = '0;
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL reset_midwait: got %b required %b", obs, exp_v);
    end
    for (int c = 0; c < 3; c++) begin
      frame_valid  = 1'b1;
      parity_error = (c == 1);
      tick();
      quiet_inputs();
      n_compared++;
      if (obs !== exp_v) begin
        n_mismatched++;
        $display("FAIL idle_no_start%0d: got %b required %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i <= MAX_RETRY; i++) begin
        plan_kind[i] = $urandom_range(2);
        plan_dly[i]  = $urandom_range(TIMEOUT + 2, 1);
      end
      run_frame($urandom_range(3), r);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_retry();
    test_timeout();
    test_fail_restart();
    test_good_on_timeout();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
